// File: rtl/tick_rate_ctrl.sv
// Selectable-rate tick divider with a two-requester, fixed-priority rate-change handshake.
// Accepted changes are deferred to the next period boundary, so no period is cut or stretched.
module tick_rate_ctrl #(
  parameter int unsigned P_FAST = 32'd500000,
  parameter int unsigned P_MED  = 32'd25000000,
  parameter int unsigned P_SLOW = 32'd50000000,
  parameter int unsigned CW     = 32'd26
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       req0_valid,
  input  logic [7:0] req0_sel,
  input  logic       req1_valid,
  input  logic [7:0] req1_sel,
  output logic       ack0,
  output logic       ack1,
  output logic       tick,
  output logic       clkout,
  output logic [7:0] cur_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PENDING = 2'd2
  } state_e;

  localparam logic [7:0]    SEL_MED   = 8'd16;
  localparam logic [7:0]    SEL_SLOW  = 8'd48;
  localparam logic [CW-1:0] LAST_FAST = CW'(P_FAST - 32'd1);
  localparam logic [CW-1:0] LAST_MED  = CW'(P_MED - 32'd1);
  localparam logic [CW-1:0] LAST_SLOW = CW'(P_SLOW - 32'd1);

  // Terminal count for a rate code; the match is on all 8 bits.
  function automatic logic [CW-1:0] last_cnt(input logic [7:0] sel);
    case (sel)
      SEL_MED:  last_cnt = LAST_MED;
      SEL_SLOW: last_cnt = LAST_SLOW;
      default:  last_cnt = LAST_FAST;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    pend_sel_q, pend_sel_d;
  logic [7:0]    cur_sel_q, cur_sel_d;
  logic          tick_q, tick_d;
  logic          clkout_q, clkout_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;

  logic          live0, live1, grant_ok, gnt0, gnt1, gnt_any, wrap;
  logic [7:0]    gnt_sel;
  logic [CW-1:0] last_cur;

  // A requester still shows valid on the edge after its ack; that stale valid is not a new request.
  assign live0    = req0_valid & ~ack0_q;
  assign live1    = req1_valid & ~ack1_q;
  assign grant_ok = ~stop & (state_q != S_PENDING);
  assign gnt0     = grant_ok & live0;
  assign gnt1     = grant_ok & ~live0 & live1;
  assign gnt_any  = gnt0 | gnt1;
  assign gnt_sel  = gnt0 ? req0_sel : req1_sel;
  assign last_cur = last_cnt(cur_sel_q);
  assign wrap     = (state_q != S_IDLE) && (cnt_q == last_cur);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_sel_d = pend_sel_q;
    cur_sel_d  = cur_sel_q;
    tick_d     = 1'b0;
    clkout_d   = clkout_q;
    ack0_d     = gnt0;
    ack1_d     = gnt1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (gnt_any) begin
          cur_sel_d = gnt_sel;
        end
        if (start && !stop) begin
          state_d = S_RUN;
        end
      end

      S_RUN, S_PENDING: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (state_q == S_PENDING) begin
            cur_sel_d = pend_sel_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (wrap) begin
            cnt_d    = '0;
            tick_d   = 1'b1;
            clkout_d = ~clkout_q;
            if (state_q == S_PENDING) begin
              cur_sel_d = pend_sel_q;
              state_d   = S_RUN;
            end
          end
          // Grants only reach here from RUN; a same-code request is acked without a change.
          if (gnt_any && (gnt_sel != cur_sel_q)) begin
            pend_sel_d = gnt_sel;
            state_d    = S_PENDING;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == S_PENDING);
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_sel_q <= '0;
      cur_sel_q  <= '0;
      tick_q     <= 1'b0;
      clkout_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_sel_q <= pend_sel_d;
      cur_sel_q  <= cur_sel_d;
      tick_q     <= tick_d;
      clkout_q   <= clkout_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign tick    = tick_q;
  assign clkout  = clkout_q;
  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;

  a_one_ack: assert property (@(posedge clkin) disable iff (!rst_n) !(ack0_q && ack1_q));
  a_busy_pending: assert property (@(posedge clkin) disable iff (!rst_n)
    busy_q == (state_q == S_PENDING));
  a_cnt_range: assert property (@(posedge clkin) disable iff (!rst_n) cnt_q <= last_cur);

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Scenario bench for tick_rate_ctrl; expected outputs come from a model that tracks
// the absolute edge of the next period boundary rather than a cycle counter.
module tb_tick_rate_ctrl;

  localparam int P_FAST = 4;
  localparam int P_MED  = 8;
  localparam int P_SLOW = 12;
  localparam int CW     = 4;

  logic       clkin      = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start      = 1'b0;
  logic       stop       = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_sel   = 8'd0;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_sel   = 8'd0;
  logic       ack0, ack1, tick, clkout, busy;
  logic [7:0] cur_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  bit         m_run, m_pending, e_tick, e_clk, e_ack0, e_ack1;
  logic [7:0] m_cur, m_pend;
  int         m_next_wrap;

  tick_rate_ctrl #(
    .P_FAST(P_FAST),
    .P_MED (P_MED),
    .P_SLOW(P_SLOW),
    .CW    (CW)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .req0_valid(req0_valid),
    .req0_sel  (req0_sel),
    .req1_valid(req1_valid),
    .req1_sel  (req1_sel),
    .ack0      (ack0),
    .ack1      (ack1),
    .tick      (tick),
    .clkout    (clkout),
    .cur_sel   (cur_sel),
    .busy      (busy)
  );

  always #5 clkin = ~clkin;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int period(input logic [7:0] sel);
    if (sel == 8'd16) return P_MED;
    if (sel == 8'd48) return P_SLOW;
    return P_FAST;
  endfunction

  // Counter value the design should hold right now, derived from the next boundary edge.
  function automatic int cnt_now();
    return period(m_cur) - 1 - (m_next_wrap - edge_n);
  endfunction

  function automatic logic [12:0] obs_vec();
    return {ack0, ack1, tick, clkout, cur_sel, busy};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {e_ack0, e_ack1, e_tick, e_clk, m_cur, m_pending};
  endfunction

  function automatic logic [7:0] pick_sel();
    case ($urandom_range(3, 0))
      0:       return 8'd0;
      1:       return 8'd16;
      2:       return 8'd48;
      default: return 8'($urandom_range(255, 0));
    endcase
  endfunction

  // Applies the rules to the inputs sampled at edge number edge_n.
  function automatic void model_edge();
    bit         live0, live1, g0, g1, wrap;
    logic [7:0] gsel;
    e_tick = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_pending = 0; m_cur = 8'd0; m_pend = 8'd0;
      e_clk = 0; e_ack0 = 0; e_ack1 = 0;
      return;
    end
    live0  = req0_valid && !e_ack0;
    live1  = req1_valid && !e_ack1;
    g0     = !stop && !m_pending && live0;
    g1     = !stop && !m_pending && !live0 && live1;
    gsel   = g0 ? req0_sel : req1_sel;
    e_ack0 = g0;
    e_ack1 = g1;
    wrap   = m_run && (edge_n == m_next_wrap);
    if (!m_run) begin
      if (g0 || g1) m_cur = gsel;
      if (start && !stop) begin
        m_run       = 1;
        m_next_wrap = edge_n + period(m_cur);
      end
    end else if (stop) begin
      if (m_pending) m_cur = m_pend;
      m_pending = 0;
      m_run     = 0;
    end else begin
      if (wrap) begin
        e_tick = 1'b1;
        e_clk  = !e_clk;
        if (m_pending) begin
          m_cur     = m_pend;
          m_pending = 0;
        end
        m_next_wrap = edge_n + period(m_cur);
      end
      if ((g0 || g1) && (gsel != m_cur)) begin
        m_pend    = gsel;
        m_pending = 1;
      end
    end
  endfunction

  // One clock edge; requesters drop valid on the edge after they saw their ack.
  task automatic cycle();
    bit a0, a1;
    a0 = e_ack0;
    a1 = e_ack1;
    @(posedge clkin);
    model_edge();
    edge_n++;
    #1;
    if (a0) req0_valid = 1'b0;
    if (a1) req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_sel = 8'd0; req1_sel = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (obs_vec() !== 13'd0) begin
        n_fail++;
        $display("FAIL reset edge=%0d got=%h exp=%h", edge_n, obs_vec(), 13'd0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    int ticks = 0;
    for (int i = 0; i < 3 * P_FAST + 2; i++) begin
      start = (i == 0);
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL start edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
      if (tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 3) begin
      n_fail++;
      $display("FAIL start_tick_count got=%0d exp=3", ticks);
    end
  endtask

  task automatic test_rate_change();
    bit issued = 1'b0;
    int last = -1;
    int gap  = 0;
    for (int i = 0; i < 40; i++) begin
      if (!issued && cnt_now() == 1) begin
        req0_sel = 8'd16; req0_valid = 1'b1; issued = 1'b1;
      end
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rate_change edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
      if (tick === 1'b1) begin
        if (last >= 0) gap = edge_n - last;
        last = edge_n;
      end
    end
    n_checks++;
    if (cur_sel !== 8'd16 || busy !== 1'b0 || gap != P_MED) begin
      n_fail++;
      $display("FAIL rate_change_final got cur=%0d busy=%b gap=%0d exp cur=16 busy=0 gap=%0d",
               cur_sel, busy, gap, P_MED);
    end
  endtask

  task automatic test_contention();
    int d         = int'($urandom_range(7, 0));
    bit seen_ack1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == d) begin
        req0_sel = 8'd48; req1_sel = 8'd16; req0_valid = 1'b1; req1_valid = 1'b1;
      end
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL contention edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
      if (!seen_ack1 && e_ack1) begin
        seen_ack1 = 1'b1;
        n_checks++;
        if (cur_sel !== 8'd48) begin
          n_fail++;
          $display("FAIL contention_ack1_order cur=%0d exp=48", cur_sel);
        end
      end
    end
    n_checks++;
    if (!seen_ack1 || cur_sel !== 8'd16) begin
      n_fail++;
      $display("FAIL contention_final ack1_seen=%b cur=%0d exp ack1_seen=1 cur=16", seen_ack1, cur_sel);
    end
  endtask

  task automatic test_same_code();
    int rq   = int'($urandom_range(14, 8));
    int last = -1;
    int gap  = 0;
    for (int i = 0; i < 36; i++) begin
      stop  = (i == 0);
      start = (i == 4);
      if (i == 2 || i == rq) begin
        req1_sel = 8'd0; req1_valid = 1'b1;
      end
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL same_code edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
      if (i > rq) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL same_code_busy edge=%0d got=%b exp=0", edge_n, busy);
        end
      end
      if (tick === 1'b1) begin
        if (last >= 0) gap = edge_n - last;
        last = edge_n;
      end
    end
    n_checks++;
    if (gap != P_FAST) begin
      n_fail++;
      $display("FAIL same_code_spacing got=%0d exp=%0d", gap, P_FAST);
    end
  endtask

  task automatic test_idle_request();
    int ticks = 0;
    for (int i = 0; i < 40; i++) begin
      stop  = (i == 0);
      start = (i == 5);
      if (i == 2) begin
        req0_sel = 8'd48; req0_valid = 1'b1;
      end
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL idle_request edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if (cur_sel !== 8'd48) begin
          n_fail++;
          $display("FAIL idle_request_direct cur=%0d exp=48", cur_sel);
        end
      end
      if (tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 2) begin
      n_fail++;
      $display("FAIL idle_request_slow_ticks got=%0d exp=2", ticks);
    end
  endtask

  task automatic test_stop_pending();
    bit stopped = 1'b0;
    int ack_i   = -1;
    for (int i = 0; i < 40; i++) begin
      start = 1'b0;
      if (i == 0) begin
        req0_sel = 8'd5; req0_valid = 1'b1;
      end
      if (i == 20) begin
        req1_sel = 8'd48; req1_valid = 1'b1;
      end
      stop = (ack_i >= 0 && i == ack_i + 1);
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stop_pending edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
      if (stop) begin
        stopped = 1'b1;
        n_checks++;
        if (cur_sel !== 8'd48 || tick !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL stop_pending_apply got cur=%0d tick=%b busy=%b exp cur=48 tick=0 busy=0",
                   cur_sel, tick, busy);
        end
      end
      if (i >= 20 && ack_i < 0 && e_ack1) ack_i = i;
    end
    stop = 1'b0;
    n_checks++;
    if (!stopped) begin
      n_fail++;
      $display("FAIL stop_pending_timeout ack1 never granted within 40 cycles");
    end
  endtask

  task automatic test_reset_pending();
    bit rst_seen = 1'b0;
    int ack_i    = -1;
    for (int i = 0; i < 24; i++) begin
      start = (i == 0);
      if (i == 2) begin
        req0_sel = 8'd0; req0_valid = 1'b1;
      end
      if (ack_i >= 0 && i == ack_i + 1) begin
        rst_n = 1'b0; req1_sel = 8'd16; req1_valid = 1'b1;
      end
      if (ack_i >= 0 && i == ack_i + 3) begin
        rst_n = 1'b1; req1_valid = 1'b0;
      end
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_pending edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
      if (!rst_n) begin
        rst_seen = 1'b1;
        n_checks++;
        if (cur_sel !== 8'd0 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_pending_clear got cur=%0d busy=%b ack0=%b ack1=%b exp all 0",
                   cur_sel, busy, ack0, ack1);
        end
      end
      if (ack_i < 0 && e_ack0) ack_i = i;
    end
    rst_n = 1'b1;
    n_checks++;
    if (!rst_seen) begin
      n_fail++;
      $display("FAIL reset_pending_timeout ack0 never granted within 24 cycles");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      stop  = ($urandom_range(39, 0) == 0);
      start = ($urandom_range(7, 0) == 0);
      rst_n = ($urandom_range(299, 0) != 0);
      if (!req0_valid && $urandom_range(5, 0) == 0) begin
        req0_sel = pick_sel(); req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(5, 0) == 0) begin
        req1_sel = pick_sel(); req1_valid = 1'b1;
      end
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random edge=%0d got=%h exp=%h", edge_n, obs_vec(), exp_vec());
      end
    end
    rst_n = 1'b1; stop = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_rate_change();
    test_contention();
    test_same_code();
    test_idle_request();
    test_stop_pending();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_rate_ctrl.md
# tick_rate_ctrl

Timebase controller that owns the selectable-rate tick divider. It generates a one-cycle `tick` enable and a legacy square-wave `clkout`, and keeps the current rate code (`cur_sel`). Two requesters can ask for a rate change through a fixed-priority valid/ack handshake. An accepted change is applied only at a tick boundary, so no tick period is ever shortened or stretched mid-count. Display and game-timing logic consume `tick`; `clkout` exists for blocks that still use the toggling clock.

## Interface
- P_FAST, 500000: period in clkin cycles for any `sel` other than 16 or 48 (10 ms at 50 MHz).
- P_MED, 25000000: period for `sel` == 16.
- P_SLOW, 50000000: period for `sel` == 48.
- CW, 26: counter width; must hold P_SLOW-1.
- clkin  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  level; move IDLE -> RUN.
- stop  in  1  level; move any state -> IDLE.
- req0_valid  in  1  requester 0 (high priority) has a rate code.
- req0_sel  in  8  requester 0 rate code.
- req1_valid  in  1  requester 1 (low priority) has a rate code.
- req1_sel  in  8  requester 1 rate code.
- ack0  out  1  one-cycle pulse: request 0 accepted.
- ack1  out  1  one-cycle pulse: request 1 accepted.
- tick  out  1  one-cycle pulse, once per period.
- clkout  out  1  toggles on every tick.
- cur_sel  out  8  rate code currently in force.
- busy  out  1  high while a change is pending.

## Operation
- States: IDLE, RUN, PENDING.
- Reset values (rst_n low at a clock edge): state IDLE, cnt 0, pend_sel 0, cur_sel 0 (FAST), tick 0, clkout 0, ack0/ack1 0, busy 0.
- Period mapping: P(sel) = P_MED if sel==16, P_SLOW if sel==48, else P_FAST. The comparison is on the full 8 bits.
- IDLE:
  - cnt held at 0; tick stays 0.
  - start=1 and stop=0: go to RUN, cnt=0.
  - A granted request writes cur_sel directly and acks; no PENDING state is entered.
- RUN:
  - cnt increments each cycle.
  - When cnt==P(cur_sel)-1: cnt<=0, tick<=1, clkout<=~clkout.
  - A granted request with sel != cur_sel: pend_sel<=sel, ack, go to PENDING.
  - A granted request with sel == cur_sel: ack only; stay in RUN.
- PENDING:
  - Counting continues with the old period.
  - At the wrap cycle (cnt==P(cur_sel)-1): cur_sel<=pend_sel, tick and clkout behave as in RUN, cnt<=0, return to RUN.
  - The next period uses the new P.
- Arbitration:
  - Grants are allowed only in IDLE or RUN, and only when stop=0.
  - req0 beats req1.
  - At most one ack per cycle.
  - A requester holds valid and sel stable until its ack; unacked requests are never lost or reordered.
- stop: from RUN or PENDING, go to IDLE with cnt<=0. From PENDING, pend_sel is written to cur_sel on that edge. No tick is produced on the stop edge.
- Simultaneous events:
  - stop and start together: stop wins.
  - Wrap and grant in the same RUN cycle: the tick fires, and the grant moves the block to PENDING for the following period.
- Reset mid-operation: all state cleared; pending request discarded without ack.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Start latency: start is sampled at edge E0. The first tick is high in the cycle following edge E0+P; thereafter one tick every P cycles exactly.
- ack latency: an ack goes high the cycle after the edge where valid was sampled and granted, and lasts exactly 1 cycle. A requester samples ack at the following edge and then drops or changes valid.
- busy is high from the cycle after the grant through the cycle containing the applying wrap edge, inclusive of that edge's result being visible. It drops in the same cycle cur_sel shows the new value.
- The period boundary is never altered. A change takes effect between 1 and P_old cycles after its ack.
- clkout period is 2*P; duty is 50%.

## Test plan
- Bench parameters: P_FAST=4, P_MED=8, P_SLOW=12.
- Reset/start: hold rst_n=0 for 3 cycles, then start=1 for 1 cycle -> all outputs 0; first tick 4 cycles after start; ticks repeat every 4 cycles; clkout toggles with each tick.
- Rate change in RUN: req0_sel=16 at cnt==1 -> ack0 pulse; busy high; the current 4-cycle period completes unchanged; then ticks every 8 cycles; cur_sel=16.
- Contention: req0 (sel 48) and req1 (sel 16) valid in the same cycle -> ack0 first; req1 unacked while busy; after the applying wrap, ack1 is granted; final cur_sel=16 after the next wrap.
- Same-code request and IDLE request:
  - In RUN, req1_sel=0 while cur_sel=0 -> ack1; busy stays 0; tick spacing unchanged.
  - In IDLE, req0_sel=48 -> cur_sel=48 the next cycle; the subsequent start gives 12-cycle ticks.
- stop in PENDING and reset mid-operation:
  - stop while pending sel=48 -> IDLE; cur_sel=48; no tick.
  - rst_n=0 during PENDING -> cur_sel=0, busy=0, no ack pulse.
